sram_multiport_arbiter: RTL
===========================

// Module: sram_multiport_arbiter
// PURPOSE
//  Shares one asynchronous 8-bit SRAM between a video fetcher and NPORTS CPU-side
//  requesters (Z80, DMA, loader). Video owns the bus whenever vid_turn=1. In CPU
//  turns, requesters are served round-robin with req/ack handshakes and a timed
//  write strobe. Sits between the ASIC/CPU memory maps and the board SRAM pins.
// PARAMETERS
//  AW        19  SRAM address width
//  DW        8   SRAM data width
//  NPORTS    2   number of CPU-side requesters (1..4)
//  WR_CYCLES 2   cycles sram_we_n is held low per write (1..4)
// PORTS
//  clk        in   1          system clock; all state on posedge
//  rst        in   1          asynchronous reset, active-high
//  vid_turn   in   1          1 = video slot, 0 = CPU slot
//  vid_addr   in   AW         video fetch address
//  vid_data   out  DW         video read data
//  req        in   NPORTS     per-port request; held until ack
//  we         in   NPORTS     per-port 1=write 0=read; stable while req=1
//  addr       in   NPORTS*AW  packed addresses, port p at [p*AW +: AW]
//  wdata      in   NPORTS*DW  packed write data
//  ack        out  NPORTS     one-cycle pulse; transaction complete
//  rdata      out  DW         read data, valid in the ack cycle
//  sram_a     out  AW         SRAM address
//  sram_we_n  out  1          SRAM write enable, active low
//  sram_d     inout DW        SRAM data bus
// BEHAVIOUR
//  - Reset: state=IDLE, ack=0, rdata=0, rr pointer=0, sram_we_n=1, sram_d=Z,
//    sram_a=0; vid_data per CONFIGURATION.
//  - vid_turn=1: sram_a=vid_addr, sram_we_n=1, sram_d=Z combinationally,
//    regardless of state.
//  - FSM states: IDLE, RD_ADDR, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD.
//  - IDLE (vid_turn=0): grant lowest port >= rr with req=1, wrapping modulo
//    NPORTS; latch port, addr, we, wdata. Go to RD_ADDR if we=0, else WR_SETUP.
//  - RD_ADDR: sram_a=addr. RD_LATCH: rdata<=sram_d, ack[p]=1, then IDLE.
//    Read latency is 3 cycles from grant to ack.
//  - WR_SETUP: drive addr and data, we_n=1. WR_PULSE: we_n=0 for WR_CYCLES
//    cycles. WR_HOLD: we_n=1, data still driven, ack[p]=1, then IDLE.
//    sram_d driven only in WR_SETUP, WR_PULSE and WR_HOLD.
//  - After each ack, rr <= (p+1) mod NPORTS, giving round-robin fairness.
//  - Preemption: vid_turn=1 in any non-IDLE state returns the FSM to IDLE with
//    no ack. The latched transaction is discarded and re-arbitrated in the next
//    CPU turn. A write pulse is never left low across a video slot.
//  - A req dropped without ack is illegal. Grants are sampled in IDLE only.
//  - At most one ack bit is high at a time. ack is never asserted while
//    vid_turn=1.
//  - Reset mid-transaction: FSM forced to IDLE, we_n=1, bus released at once.
// CONFIGURATION
//  VID_RDREG_EN defined: vid_data <= sram_d on each posedge while vid_turn=1,
//    giving 1-cycle latency; holds its value otherwise; reset value 0.
//  Not defined: vid_data = sram_d combinationally, with 0 latency.
// TESTING
//  1. Port0 read addr 0x12345 with SRAM model holding 0xA5, vid_turn=0
//     -> ack[0] 3 cycles after grant, rdata=0xA5, sram_we_n stays 1.
//  2. Port1 write 0x5A to 0x00010, WR_CYCLES=2 -> we_n low exactly 2 cycles,
//     sram_d=0x5A from WR_SETUP through WR_HOLD, model reads back 0x5A.
//  3. Ports 0 and 1 requesting continuously -> acks alternate 0,1,0,1;
//     neither port starved.
//  4. vid_turn rises during WR_PULSE -> we_n=1 and sram_a=vid_addr in the same
//     cycle; no ack; write re-executed and acked in the next CPU turn.
//  5. vid_turn=1, vid_addr=0x7FFFF holding 0x3C -> vid_data=0x3C (the next
//     cycle if VID_RDREG_EN); no CPU ack during the slot.
//  6. rst pulsed mid-write -> sram_we_n=1 and sram_d=Z immediately; FSM in
//     IDLE; ack=0.

Source files
------------

// File: rtl/sram_multiport_arbiter_if.sv
// CPU-side request bus shared by NPORTS requesters (Z80, DMA, loader).
// Latency: n/a (signal bundle only).
// Backpressure: req is held by the requester until its one-cycle ack pulse.
//   req/we/addr/wdata : requester -> arbiter, port p at [p*AW +: AW] / [p*DW +: DW]
//   ack/rdata         : arbiter -> requester, rdata valid in the ack cycle
interface sram_multiport_arbiter_if #(
   parameter int AW     = 19,
   parameter int DW     = 8,
   parameter int NPORTS = 2
);
   logic [NPORTS-1:0]    req;
   logic [NPORTS-1:0]    we;
   logic [NPORTS*AW-1:0] addr;
   logic [NPORTS*DW-1:0] wdata;
   logic [NPORTS-1:0]    ack;
   logic [DW-1:0]        rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_multiport_arbiter.sv
// Shares one async SRAM between video (owns bus when vid_turn=1) and round-robin CPU ports.
// Latency: read ack 3 cycles after grant; write ack WR_CYCLES+3 cycles after grant.
// Backpressure: requests wait in req until granted; video slots abort and re-arbitrate.
// Ports:
//   clk, rst (async, active-high)   vid_turn, vid_addr, vid_data : video fetch path
//   cpu (slave modport)             : req/we/addr/wdata in, ack/rdata out
//   sram_a, sram_we_n, sram_d       : board SRAM pins
// Optional build macro VID_RDREG_EN: registers vid_data (1-cycle latency) instead of
// passing sram_d straight through.
module sram_multiport_arbiter #(
   parameter int AW        = 19,
   parameter int DW        = 8,
   parameter int NPORTS    = 2,
   parameter int WR_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vid_turn,
   input  logic [AW-1:0]          vid_addr,
   output logic [DW-1:0]          vid_data,
   sram_multiport_arbiter_if.slave cpu,
   output logic [AW-1:0]          sram_a,
   output logic                   sram_we_n,
   inout  wire  [DW-1:0]          sram_d
);

   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_q, p_q, gnt_p, nxt_rr;
   logic [AW-1:0]     a_q;
   logic [DW-1:0]     wd_q, rdata_q;
   logic [NPORTS-1:0] ack_q, req_eff, p_onehot;
   logic [1:0]        cnt_q;
   logic              gnt_vld, take, done, drive;

   // A completed ack that lands in a video slot is held back until the next
   // CPU slot; masking the acked port stops it being re-granted while its
   // requester is still dropping req.
   always_comb begin
      int j;
      j       = 0;
      req_eff = cpu.req & ~ack_q;
      gnt_vld = 1'b0;
      gnt_p   = '0;
      for (int i = 0; i < NPORTS; i++) begin
         j = int'(rr_q) + i;
         if (j >= NPORTS) j = j - NPORTS;
         if (!gnt_vld && req_eff[j]) begin
            gnt_vld = 1'b1;
            gnt_p   = PW'(j);
         end
      end
   end

   always_comb begin
      p_onehot      = '0;
      p_onehot[p_q] = 1'b1;
      nxt_rr        = (int'(p_q) == NPORTS - 1) ? '0 : p_q + 1'b1;
   end

   assign take = (state_q == IDLE) && !vid_turn && gnt_vld;
   assign done = !vid_turn && ((state_q == RD_LATCH) || (state_q == WR_HOLD));

   // Next state; any video slot outside IDLE abandons the transaction.
   always_comb begin
      state_d = state_q;
      if (state_q != IDLE && vid_turn) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     if (take) state_d = cpu.we[gnt_p] ? WR_SETUP : RD_ADDR;
            RD_ADDR:  state_d = RD_LATCH;
            RD_LATCH: state_d = IDLE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (cnt_q == 2'(WR_CYCLES - 1)) state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         p_q     <= '0;
         a_q     <= '0;
         wd_q    <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == WR_PULSE && !vid_turn) cnt_q <= cnt_q + 2'd1;
         else                                  cnt_q <= '0;
         if (take) begin
            p_q  <= gnt_p;
            a_q  <= cpu.addr[int'(gnt_p)*AW +: AW];
            wd_q <= cpu.wdata[int'(gnt_p)*DW +: DW];
         end
         if (done) begin
            rr_q  <= nxt_rr;
            ack_q <= p_onehot;
         end else if (!vid_turn) begin
            ack_q <= '0;
         end
         if (state_q == RD_LATCH && !vid_turn) rdata_q <= sram_d;
      end
   end

   // Pin muxing is combinational so a video slot or reset takes the bus at once.
   assign drive     = !vid_turn && ((state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                                    (state_q == WR_HOLD));
   assign sram_a    = vid_turn ? vid_addr : a_q;
   assign sram_we_n = vid_turn || (state_q != WR_PULSE);
   assign sram_d    = drive ? wd_q : {DW{1'bz}};

   assign cpu.ack   = vid_turn ? '0 : ack_q;
   assign cpu.rdata = rdata_q;

`ifdef VID_RDREG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           vid_data <= '0;
      else if (vid_turn) vid_data <= sram_d;
   end
`else
   assign vid_data = sram_d;
`endif

endmodule
